// File: rtl/ring_req_array.sv
// Array of independent ring-protocol progress trackers, one FSM per channel.
// Outputs are pure decodes of registered state; no input reaches an output combinationally.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_INIT | first cycle after reset, all channel state cleared
//   ST_RUN  | advancing progress, counting consecutive losses
//   ST_DONE | progress saturated at K-1, waiting for stability/restart
//   ST_FAIL | loss budget exhausted, held until restart or reset
module ring_req_array #(
    parameter int K       = 4,
    parameter int NCH     = 2,
    parameter int MAXLOSS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     restart,
    input  logic [NCH-1:0]     loss,
    input  logic [NCH-1:0]     controllable_stable,
    output logic [NCH*6-1:0]   prg_flat,
    output logic [NCH-1:0]     done,
    output logic [NCH-1:0]     fail,
    output logic               error,
    output logic               objective
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    logic [NCH-1:0] w_unsafe;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t       r_state  = ST_INIT;
        logic [5:0]   r_prg    = '0;
        logic [7:0]   r_lcnt   = '0;
        logic         r_stable = 1'b0;

        state_t       w_state_nxt;
        logic [5:0]   w_prg_nxt;
        logic [7:0]   w_lcnt_nxt;
        logic         w_stable_nxt;
        logic [8:0]   w_lcnt_inc;

        assign w_lcnt_inc = {1'b0, r_lcnt} + 9'd1;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state  <= ST_INIT;
                r_prg    <= '0;
                r_lcnt   <= '0;
                r_stable <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_prg    <= w_prg_nxt;
                r_lcnt   <= w_lcnt_nxt;
                r_stable <= w_stable_nxt;
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_prg_nxt    = r_prg;
            w_lcnt_nxt   = r_lcnt;
            w_stable_nxt = r_stable;
            case (r_state)
                ST_INIT: begin
                    w_state_nxt  = ST_RUN;
                    w_prg_nxt    = '0;
                    w_lcnt_nxt   = '0;
                    w_stable_nxt = 1'b0;
                end
                ST_RUN: begin
                    if (restart[g]) begin
                        w_prg_nxt    = '0;
                        w_lcnt_nxt   = '0;
                        w_stable_nxt = 1'b0;
                    end else if (loss[g]) begin
                        // Reaching the budget leaves RUN, so lcnt can never pass MAXLOSS.
                        w_lcnt_nxt = w_lcnt_inc[7:0];
                        if (w_lcnt_inc == 9'(MAXLOSS))
                            w_state_nxt = ST_FAIL;
                    end else begin
                        w_lcnt_nxt = '0;
                        if (r_prg == 6'(K-2)) begin
                            w_prg_nxt    = 6'(K-1);
                            w_stable_nxt = controllable_stable[g];
                            w_state_nxt  = ST_DONE;
                        end else begin
                            w_prg_nxt = r_prg + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    w_prg_nxt = 6'(K-1);
                    if (restart[g]) begin
                        w_state_nxt  = ST_RUN;
                        w_prg_nxt    = '0;
                        w_lcnt_nxt   = '0;
                        w_stable_nxt = 1'b0;
                    end else if (controllable_stable[g]) begin
                        w_stable_nxt = 1'b1;
                    end
                end
                ST_FAIL: begin
                    if (restart[g]) begin
                        w_state_nxt  = ST_RUN;
                        w_prg_nxt    = '0;
                        w_lcnt_nxt   = '0;
                        w_stable_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end

        assign prg_flat[6*g +: 6] = r_prg;
        assign done[g]            = (r_state == ST_DONE);
        assign fail[g]            = (r_state == ST_FAIL);
        assign w_unsafe[g]        = ((r_state == ST_DONE) && !r_stable) || (r_state == ST_FAIL);
    end

    assign error     = |w_unsafe;
    assign objective = &done;

endmodule

// File: tb/tb_ring_req_array.sv
// Self-checking bench for ring_req_array: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a per-channel behavioural model.
module tb_ring_req_array;
    localparam int K       = 4;
    localparam int NCH     = 2;
    localparam int MAXLOSS = 3;
    localparam int S_INIT = 0, S_RUN = 1, S_DONE = 2, S_FAIL = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   restart = '0;
    logic [NCH-1:0]   loss = '0;
    logic [NCH-1:0]   cs = '0;
    logic [NCH*6-1:0] prg_flat;
    logic [NCH-1:0]   done;
    logic [NCH-1:0]   fail;
    logic             error;
    logic             objective;

    int n_tests = 0;
    int n_fail  = 0;

    int m_st   [NCH];
    int m_prg  [NCH];
    int m_lcnt [NCH];
    bit m_stab [NCH];

    ring_req_array #(.K(K), .NCH(NCH), .MAXLOSS(MAXLOSS)) dut (
        .clk                 (clk),
        .reset               (reset),
        .restart             (restart),
        .loss                (loss),
        .controllable_stable (cs),
        .prg_flat            (prg_flat),
        .done                (done),
        .fail                (fail),
        .error               (error),
        .objective           (objective)
    );

    always #5 clk = ~clk;

    task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear(input int ch, input int st);
        m_st[ch]   = st;
        m_prg[ch]  = 0;
        m_lcnt[ch] = 0;
        m_stab[ch] = 1'b0;
    endtask

    task automatic model_tick();
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset) begin
                model_clear(ch, S_INIT);
            end else if (m_st[ch] == S_INIT) begin
                model_clear(ch, S_RUN);
            end else if (m_st[ch] == S_RUN) begin
                if (restart[ch]) model_clear(ch, S_RUN);
                else if (loss[ch]) begin
                    m_lcnt[ch] += 1;
                    if (m_lcnt[ch] == MAXLOSS) m_st[ch] = S_FAIL;
                end else begin
                    m_lcnt[ch] = 0;
                    m_prg[ch] += 1;
                    if (m_prg[ch] == K-1) begin
                        m_st[ch]   = S_DONE;
                        m_stab[ch] = cs[ch];
                    end
                end
            end else if (m_st[ch] == S_DONE) begin
                if (restart[ch]) model_clear(ch, S_RUN);
                else if (cs[ch]) m_stab[ch] = 1'b1;
            end else begin
                if (restart[ch]) model_clear(ch, S_RUN);
            end
        end
    endtask

    task automatic check_all();
        logic [NCH*6-1:0] e_prg;
        logic [NCH-1:0]   e_done, e_fail;
        logic             e_err, e_obj;
        e_err = 1'b0;
        e_obj = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            e_prg[6*i +: 6] = 6'(m_prg[i]);
            e_done[i] = (m_st[i] == S_DONE);
            e_fail[i] = (m_st[i] == S_FAIL);
            if ((e_done[i] && !m_stab[i]) || e_fail[i]) e_err = 1'b1;
            if (!e_done[i]) e_obj = 1'b0;
        end
        compare("prg_flat",  64'(prg_flat),  64'(e_prg));
        compare("done",      64'(done),      64'(e_done));
        compare("fail",      64'(fail),      64'(e_fail));
        compare("error",     64'(error),     64'(e_err));
        compare("objective", 64'(objective), 64'(e_obj));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
        check_all();
    endtask

    task automatic lit_zero(input string nm);
        compare({nm, "_prg"},  64'(prg_flat), 64'd0);
        compare({nm, "_done"}, 64'(done),     64'd0);
        compare({nm, "_fail"}, 64'(fail),     64'd0);
        compare({nm, "_err"},  64'(error),    64'd0);
        compare({nm, "_obj"},  64'(objective), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; restart = '0; loss = '0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int exp_prg0 [6];
        exp_prg0 = '{0, 1, 1, 2, 2, 3};
        for (int ch = 0; ch < NCH; ch++) model_clear(ch, S_INIT);

        #1;
        lit_zero("powerup");
        check_all();

        // Completion with full stability
        cycle(); cycle();
        lit_zero("in_reset");
        reset = 1'b0; cs = 2'b11;
        cycle();
        lit_zero("after_reset");
        cycle(); cycle();
        compare("run_prg2", 64'(prg_flat), 64'h082);
        cycle();
        compare("done_prg3", 64'(prg_flat), 64'h0C3);
        compare("done_both", 64'(done), 64'd3);
        compare("objective_hi", 64'(objective), 64'd1);
        compare("error_lo", 64'(error), 64'd0);

        // Unstable completion, then a one-cycle grant latches stability
        do_reset(); cs = 2'b10;
        repeat (4) cycle();
        compare("unstable_done", 64'(done), 64'd3);
        compare("unstable_err", 64'(error), 64'd1);
        cs = 2'b11;
        cycle();
        compare("grant_err", 64'(error), 64'd0);
        cs = 2'b10;
        repeat (3) cycle();
        compare("grant_sticky", 64'(error), 64'd0);

        // Loss budget on channel 1, then restart
        do_reset(); cs = 2'b11;
        cycle(); cycle();
        loss = 2'b10;
        cycle();
        compare("loss1_fail", 64'(fail), 64'd0);
        cycle();
        compare("loss2_fail", 64'(fail), 64'd0);
        cycle();
        compare("loss3_fail", 64'(fail), 64'd2);
        compare("loss3_prg1", 64'(prg_flat[11:6]), 64'd1);
        compare("loss3_err", 64'(error), 64'd1);
        loss = '0; restart = 2'b10;
        cycle();
        compare("restart_fail", 64'(fail), 64'd0);
        compare("restart_prg1", 64'(prg_flat[11:6]), 64'd0);
        restart = '0;

        // Alternating loss never exhausts the budget
        do_reset();
        cycle();
        for (int i = 0; i < 6; i++) begin
            loss = {1'b0, (i % 2 == 0)};
            cycle();
            compare("alt_fail", 64'(fail), 64'd0);
            compare("alt_prg0", 64'(prg_flat[5:0]), 64'(exp_prg0[i]));
        end
        loss = '0;

        // Restart beats loss and clears the loss count
        do_reset();
        cycle(); cycle(); cycle();
        compare("pre_prg0", 64'(prg_flat[5:0]), 64'd2);
        restart = 2'b01; loss = 2'b01;
        cycle();
        compare("rl_prg0", 64'(prg_flat[5:0]), 64'd0);
        restart = '0;
        cycle(); cycle();
        compare("rl_lcnt_clear", 64'(fail[0]), 64'd0);
        cycle();
        compare("rl_third_loss", 64'(fail[0]), 64'd1);
        loss = '0;

        // Reset while one channel is DONE and the other FAIL
        do_reset(); cs = 2'b01;
        cycle();
        loss = 2'b10;
        repeat (3) cycle();
        compare("mix_done", 64'(done), 64'd1);
        compare("mix_fail", 64'(fail), 64'd2);
        reset = 1'b1; loss = '0;
        cycle();
        lit_zero("mid_reset");
        reset = 1'b0;
        cycle();
        lit_zero("mid_reset_run");
        cycle();
        compare("mid_reset_adv", 64'(prg_flat), 64'h041);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(63) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                restart[ch] = ($urandom_range(9) == 0);
                loss[ch]    = ($urandom_range(2) == 0);
                cs[ch]      = ($urandom_range(3) == 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
